// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter, fractional baud generator, optional TX FIFO (UART_TX_FIFO_EN)
module uart_tx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [63:0] INC64 =
        ((64'(BAUD) << (ACC_WIDTH - 4)) + 64'(CLK_FREQ >> 5)) / 64'(CLK_FREQ >> 4);
    localparam logic [ACC_WIDTH:0] INC = INC64[ACC_WIDTH:0];
    localparam logic [3:0] CNT_LAST  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_nx;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     sum;
    logic                   tick;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   load_word;
    logic                   par_bit, par_calc;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   shift, txd_nx, start_load;
    logic                   word_avail, hold_en;

    assign sum        = {1'b0, acc} + INC;
    assign tick       = sum[ACC_WIDTH];
    assign start_load = (state_nx == S_START) && (state != S_START);
    assign par_calc   = (PARITY == 1) ? ~^load_word : ^load_word;
    assign tx_busy    = (state != S_IDLE) | word_avail;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count;
    logic                 push, pop;

    assign tx_ready   = (count != LW'(FIFO_DEPTH));
    assign push       = tx_valid & tx_ready;
    assign pop        = start_load;
    assign word_avail = (count != '0);
    assign load_word  = mem[rd_ptr];
    assign tx_level   = count;
    assign hold_en    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
`else
    // The shift register doubles as the one-word holding slot while pending.
    logic pending;

    assign tx_ready   = (state == S_IDLE) & ~pending;
    assign hold_en    = tx_valid & tx_ready;
    assign word_avail = pending;
    assign load_word  = shreg;
    assign tx_level   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pending <= 1'b0;
        else if (hold_en)    pending <= 1'b1;
        else if (start_load) pending <= 1'b0;
    end
`endif

    always_comb begin
        state_nx = state;
        shift    = 1'b0;
        case (state)
            S_IDLE:   if (word_avail) state_nx = S_START;
            S_START:  if (tick) state_nx = S_DATA;
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt == CNT_LAST) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                     shift = 1'b1;
                end
            end
            S_PARITY: if (tick) state_nx = S_STOP;
            S_STOP: begin
                if (tick && (stop_cnt == STOP_LAST)) state_nx = word_avail ? S_START : S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Line value is computed for the state being entered so txd changes on the same edge.
    always_comb begin
        txd_nx = 1'b1;
        case (state_nx)
            S_START:  txd_nx = 1'b0;
            S_DATA:   txd_nx = shift ? shreg[1] : shreg[0];
            S_PARITY: txd_nx = par_bit;
            default:  txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            txd      <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            state <= state_nx;
            txd   <= txd_nx;
            if (start_load)          acc <= '0;
            else if (state != S_IDLE) acc <= sum[ACC_WIDTH-1:0];
            if (hold_en)             shreg <= tx_data;
            else if (start_load)     shreg <= load_word;
            else if (shift)          shreg <= shreg >> 1;
            if (start_load) begin
                par_bit <= par_calc;
                bit_cnt <= '0;
            end else if (state == S_DATA && tick) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state != S_STOP)     stop_cnt <= 1'b0;
            else if (tick)           stop_cnt <= stop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench for uart_tx_param (8N1, 7E2, 7O2, FIFO depth 4)
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] tx_data = '0;
    logic       valid_v [4];
    logic       txd_w [4];
    logic       rdy_w [4];
    logic       busy_w [4];
    logic [4:0] lvl0, lvl1, lvl2;
    logic [2:0] lvl3;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         peak5 = 0;
    int         saw_low5 = 0;
    bit         done5 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(valid_v[0]),
        .tx_ready(rdy_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_level(lvl0));
    uart_tx_param #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(valid_v[1]),
        .tx_ready(rdy_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_level(lvl1));
    uart_tx_param #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16), .DATA_BITS(7),
                    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(valid_v[2]),
        .tx_ready(rdy_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_level(lvl2));
    uart_tx_param #(.CLK_FREQ(1600000), .BAUD(100000), .ACC_WIDTH(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(valid_v[3]),
        .tx_ready(rdy_w[3]), .txd(txd_w[3]), .tx_busy(busy_w[3]), .tx_level(lvl3));

    function automatic int lvl_of(input int s);
        case (s)
            0: return int'(lvl0);
            1: return int'(lvl1);
            2: return int'(lvl2);
            default: return int'(lvl3);
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input int s, input logic [8:0] d);
        int t;
        t = 0;
        tx_data = d;
        valid_v[s] = 1'b1;
        while (rdy_w[s] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", int'(t < 3000), 1);
        @(negedge clk);
        valid_v[s] = 1'b0;
    endtask

    // Waits for a start bit, then compares every sampled cycle against the 16-clk-per-bit frame.
    task automatic capture(input int s, input int nbits, input logic [15:0] fr, input string tag,
                           output int start_cyc, output logic busy_last, output logic rdy_mid);
        int errs, t;
        errs = 0;
        t = 0;
        busy_last = 1'b0;
        rdy_mid = 1'b0;
        while (txd_w[s] !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, int'(t < 3000), 1);
        start_cyc = cyc;
        for (int c = 0; c < nbits * 16; c++) begin
            if (txd_w[s] !== fr[c / 16]) errs++;
            if (c == 8) rdy_mid = rdy_w[s];
            if (c == nbits * 16 - 1) busy_last = busy_w[s];
            @(negedge clk);
        end
        check({tag, "_wave"}, errs, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, t, zeros;
        logic bl, rm;
        logic [15:0] frames5 [6];
        logic [8:0]  words5 [6];
        for (int i = 0; i < 4; i++) valid_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd_held", int'(txd_w[0]), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txd", int'(txd_w[0]), 1);
        check("rst_ready", int'(rdy_w[0]), 1);
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_level", lvl_of(0), 0);
        check("rst_level_u3", lvl_of(3), 0);

        // 1: 8N1 0x55
        fork
            send(0, 9'h055);
            capture(0, 10, 16'h02AA, "t1", s1, bl, rm);
        join
        check("t1_busy_last", int'(bl), 1);
        check("t1_busy_fall", int'(busy_w[0]), 0);

        // 2: 7E2 and 7O2 with 0x41
        fork
            send(1, 9'h041);
            capture(1, 11, 16'h0682, "t2e", s1, bl, rm);
        join
        check("t2e_busy_last", int'(bl), 1);
        check("t2e_busy_fall", int'(busy_w[1]), 0);
        fork
            send(2, 9'h041);
            capture(2, 11, 16'h0782, "t2o", s1, bl, rm);
        join
        check("t2o_busy_fall", int'(busy_w[2]), 0);

        // 3: reset in the middle of data bit 3
        fork
            send(0, 9'h000);
            begin
                t = 0;
                while (txd_w[0] !== 1'b0 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
            end
        join
        check("t3_start", int'(t < 3000), 1);
        repeat (72) @(negedge clk);
        check("t3_pre_reset_txd", int'(txd_w[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t3_async_txd", int'(txd_w[0]), 1);
        check("t3_ready", int'(rdy_w[0]), 1);
        check("t3_busy", int'(busy_w[0]), 0);
        check("t3_level", lvl_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            send(0, 9'h0A3);
            capture(0, 10, 16'h0346, "t3", s1, bl, rm);
        join

        // 4: valid held across two words
        fork
            begin
                send(0, 9'h001);
                send(0, 9'h002);
            end
            begin
                capture(0, 10, 16'h0202, "t4a", s1, bl, rm);
                capture(0, 10, 16'h0204, "t4b", s2, bl, bl);
            end
        join
`ifdef UART_TX_FIFO_EN
        check("t4_ready_mid", int'(rm), 1);
        check("t4_gap", s2 - s1, 160);
`else
        check("t4_ready_mid", int'(rm), 0);
        check("t4_gap", s2 - s1, 162);
`endif

`ifdef UART_TX_FIFO_EN
        // 5: six words into a depth-4 FIFO
        words5  = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
        frames5 = '{16'h0222, 16'h0244, 16'h0266, 16'h0288, 16'h02AA, 16'h02CC};
        fork
            begin
                for (int i = 0; i < 6; i++) send(3, words5[i]);
            end
            begin
                int sa, sp;
                logic b5, r5;
                sp = 0;
                for (int i = 0; i < 6; i++) begin
                    capture(3, 10, frames5[i], "t5", sa, b5, r5);
                    if (i > 0) check("t5_gap", sa - sp, 160);
                    sp = sa;
                end
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    if (lvl_of(3) > peak5) peak5 = lvl_of(3);
                    if (rdy_w[3] === 1'b0) saw_low5 = 1;
                    @(negedge clk);
                end
            end
        join
        check("t5_peak", peak5, 4);
        check("t5_ready_low", saw_low5, 1);
        check("t5_level_end", lvl_of(3), 0);

        // 6: push coinciding with pop
        tx_data = 9'h0A5;
        valid_v[3] = 1'b1;
        @(negedge clk);
        check("t6_level_push", lvl_of(3), 1);
        tx_data = 9'h05A;
        @(negedge clk);
        valid_v[3] = 1'b0;
        check("t6_level_pushpop", lvl_of(3), 1);
        check("t6_popped_txd", int'(txd_w[3]), 0);
        capture(3, 10, 16'h034A, "t6a", s1, bl, rm);
        capture(3, 10, 16'h02B4, "t6b", s2, bl, rm);
        check("t6_gap", s2 - s1, 160);
        zeros = 0;
        repeat (48) begin
            if (txd_w[3] !== 1'b1) zeros++;
            @(negedge clk);
        end
        check("t6_no_extra", zeros, 0);
        check("t6_level_end", lvl_of(3), 0);
`else
        fork
            send(3, 9'h03C);
            capture(3, 10, 16'h0278, "t5n", s1, bl, rm);
        join
        check("t5n_level", lvl_of(3), 0);
        check("t5n_busy", int'(busy_w[3]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
